// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA modular-exponentiation core.
package rsa_pkg;

  localparam int RSA_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    CONV_P,
    CONV_X,
    SQUARE,
    MULT,
    CONV_OUT,
    DONE
  } rsa_state_e;

  // Montgomery reduction needs an odd modulus >= 3, and R^2 mod M must already be reduced.
  function automatic logic operand_bad(input logic [63:0] m, input logic [63:0] r2);
    return (m[0] == 1'b0) || (m < 64'd3) || (r2 >= m);
  endfunction

endpackage

// File: rtl/rsa_mont_mul.sv
// Bit-serial Montgomery multiplier: p = a*b*R^-1 mod m, rdy pulses N+1 cycles after go.
module rsa_mont_mul
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] p,
  output logic             rdy
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] a_sh, b_r, m_r, s_red;
  logic [WIDTH+1:0] s;
  logic [CW-1:0]    cnt;
  logic             run;

  // One radix-2 step; S stays below 2M so N+2 bits never overflow.
  function automatic logic [WIDTH+1:0] step(input logic [WIDTH+1:0] acc, input logic bit_a,
                                            input logic [WIDTH-1:0] bb, input logic [WIDTH-1:0] mm);
    logic [WIDTH+1:0] t;
    t = acc + (bit_a ? {2'b00, bb} : '0);
    if (t[0]) t = t + {2'b00, mm};
    return t >> 1;
  endfunction

  assign s_red = WIDTH'((s >= {2'b00, m_r}) ? s - {2'b00, m_r} : s);

  // The go edge performs bit 0 directly, N-1 edges finish the scan, the last edge reduces.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh <= '0;
      b_r  <= '0;
      m_r  <= '0;
      s    <= '0;
      cnt  <= '0;
      run  <= 1'b0;
      p    <= '0;
      rdy  <= 1'b0;
    end else begin
      rdy <= 1'b0;
      if (go) begin
        s    <= step('0, a[0], b, m);
        a_sh <= a >> 1;
        b_r  <= b;
        m_r  <= m;
        cnt  <= CW'(WIDTH - 1);
        run  <= 1'b1;
      end else if (run) begin
        if (cnt != '0) begin
          s    <= step(s, a_sh[0], b_r, m_r);
          a_sh <= a_sh >> 1;
          cnt  <= cnt - CW'(1);
        end else begin
          p   <= s_red;
          rdy <= 1'b1;
          run <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/rsa_modexp_core.sv
// Left-to-right Montgomery exponentiation: result = plain_text^exp mod mod.
module rsa_modexp_core
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] plain_text,
  input  logic [WIDTH-1:0] exp,
  input  logic [WIDTH-1:0] mod,
  input  logic [WIDTH-1:0] mont_const,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  rsa_state_e       state, state_n;
  logic [WIDTH-1:0] p_r, e_r, m_r, r2_r, pbar, x, mm_a, mm_b, mm_p;
  logic [IW-1:0]    idx;
  logic             go_q, issue_n, mm_rdy, mm_rst, abort, accept, bad;

  assign busy   = (state != IDLE) && (state != DONE);
  assign abort  = stop && busy;
  assign accept = start && !stop && !busy;
  assign bad    = operand_bad(64'(mod), 64'(mont_const));
  // Abort also flushes any multiply in flight so no stale rdy reaches a new operation.
  assign mm_rst = rst || abort;

  rsa_mont_mul #(.WIDTH(WIDTH)) u_mul (
    .clk (clk),
    .rst (mm_rst),
    .go  (go_q),
    .a   (mm_a),
    .b   (mm_b),
    .m   (m_r),
    .p   (mm_p),
    .rdy (mm_rdy)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state, multiplier operand select and issue of the next multiply.
  always_comb begin
    state_n = state;
    mm_a    = x;
    mm_b    = x;
    issue_n = 1'b0;
    case (state)
      IDLE, DONE: if (accept) begin
        state_n = bad ? DONE : CONV_P;
        issue_n = !bad;
      end
      CONV_P: begin
        mm_a = p_r;
        mm_b = r2_r;
        if (mm_rdy) begin
          state_n = CONV_X;
          issue_n = 1'b1;
        end
      end
      CONV_X: begin
        mm_a = ONE;
        mm_b = r2_r;
        if (mm_rdy) begin
          state_n = SQUARE;
          issue_n = 1'b1;
        end
      end
      SQUARE: if (mm_rdy) begin
        issue_n = 1'b1;
        if (e_r[idx])        state_n = MULT;
        else if (idx == '0)  state_n = CONV_OUT;
      end
      MULT: begin
        mm_b = pbar;
        if (mm_rdy) begin
          issue_n = 1'b1;
          state_n = (idx == '0) ? CONV_OUT : SQUARE;
        end
      end
      CONV_OUT: begin
        mm_b = ONE;
        if (mm_rdy) state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
    if (abort) begin
      state_n = IDLE;
      issue_n = 1'b0;
    end
  end

  // Operand capture, Pbar/X/bit-index updates and the sticky status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_r    <= '0;
      e_r    <= '0;
      m_r    <= '0;
      r2_r   <= '0;
      pbar   <= '0;
      x      <= '0;
      idx    <= '0;
      go_q   <= 1'b0;
      result <= '0;
      done   <= 1'b0;
      error  <= 1'b0;
    end else begin
      go_q <= issue_n;
      if (accept) begin
        p_r   <= plain_text;
        e_r   <= exp;
        m_r   <= mod;
        r2_r  <= mont_const;
        idx   <= IW'(WIDTH - 1);
        done  <= bad;
        error <= bad;
        if (bad) result <= '0;
      end else if (mm_rdy && busy && !abort) begin
        case (state)
          CONV_P: pbar <= mm_p;
          CONV_X: x    <= mm_p;
          SQUARE: begin
            x <= mm_p;
            if (!e_r[idx] && idx != '0) idx <= idx - IW'(1);
          end
          MULT: begin
            x <= mm_p;
            if (idx != '0) idx <= idx - IW'(1);
          end
          CONV_OUT: begin
            result <= mm_p;
            done   <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
